// File: rtl/link_pkg.sv
// Shared definitions for the byte link: buffer geometry, receiver states and 8N1 frame constants.
package link_pkg;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;
endpackage

// File: rtl/rx_fifo.sv
// 16x8 first-word-fall-through receive queue with occupancy count and overrun pulse.
module rx_fifo
    import link_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             ovr
);
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

    // A pop on an empty queue is ignored; a push into a full queue only lands if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovr     = push && full && !do_pop;

    assign dout = empty ? 8'h00 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/receive_buffer.sv
// 8N1 serial receiver feeding a 16-entry receive queue, with sticky framing and overrun flags.
module receive_buffer
    import link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr,
    output logic [7:0] dataout,
    output logic       rbneout,
    output logic [4:0] countout,
    output logic       ferrout,
    output logic       ovrout
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] baud, baud_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift, shift_next;
    logic             sync1, rxs;
    logic             push, ferr_set;
    logic             fifo_full, fifo_empty, fifo_ovr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
        end
    end

    // Baud counter restarts on every sample so each sample lands mid-bit relative to START entry.
    always_comb begin
        state_next = state;
        baud_next  = baud + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift;
        push       = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (rxs == START_BIT) begin
                    state_next = START;
                    bit_next   = '0;
                end
            end
            START: begin
                if (baud == HALF_LAST) begin
                    baud_next  = '0;
                    state_next = (rxs == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (baud == FULL_LAST) begin
                    baud_next  = '0;
                    shift_next = {rxs, shift[7:1]};
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud == FULL_LAST) begin
                    baud_next = '0;
                    if (rxs == STOP_BIT) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = WAITHI;
                    end
                end
            end
            WAITHI: begin
                baud_next = '0;
                if (rxs == STOP_BIT) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase
    end

    rx_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (shift),
        .pop     (rd),
        .dout    (dataout),
        .count   (countout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ovr     (fifo_ovr)
    );

    assign rbneout = !fifo_empty;

    // A new error in the same cycle as clr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ferrout <= 1'b0;
            ovrout  <= 1'b0;
        end else begin
            if (ferr_set) begin
                ferrout <= 1'b1;
            end else if (clr) begin
                ferrout <= 1'b0;
            end
            if (fifo_ovr) begin
                ovrout <= 1'b1;
            end else if (clr) begin
                ovrout <= 1'b0;
            end
        end
    end

    full_count_consistent: assert property (
        @(posedge clk) disable iff (!reset_n) fifo_full |-> (countout == 5'd16)
    );
endmodule

// File: tb/tb_receive_buffer.sv
// Bench for receive_buffer: drives 8N1 frames and compares against a queue-based reference model.
module tb_receive_buffer;
    localparam int CPB = 16;
    localparam int STOP_NEG = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] dataout;
    logic       rbneout;
    logic [4:0] countout;
    logic       ferrout;
    logic       ovrout;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         m_ferr = 1'b0;
    bit         m_ovr = 1'b0;

    receive_buffer #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rxd      (rxd),
        .rd       (rd),
        .clr      (clr),
        .dataout  (dataout),
        .rbneout  (rbneout),
        .countout (countout),
        .ferrout  (ferrout),
        .ovrout   (ovrout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] expect_vec();
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        return {q.size() != 0, 5'(q.size()), head, m_ferr, m_ovr};
    endfunction

    function automatic logic [15:0] observed_vec();
        return {rbneout, countout, dataout, ferrout, ovrout};
    endfunction

    // Reference behaviour of one completed frame.
    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit pop_same);
        if (!stop_ok) begin
            m_ferr = 1'b1;
        end else if (pop_same && q.size() > 0) begin
            void'(q.pop_front());
            q.push_back(b);
        end else if (q.size() == 16) begin
            m_ovr = 1'b1;
        end else begin
            q.push_back(b);
        end
    endfunction

    task automatic idle_line(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rd_at_stop);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            rxd = frame[i / CPB];
            rd  = rd_at_stop && (i == STOP_NEG);
            @(negedge clk);
        end
        rd = 1'b0;
    endtask

    task automatic do_read();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (observed_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", observed_vec(), 16'h0000);
        end
        reset_n = 1'b1;
        idle_line(4);
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 1'b1, 1'b0);
        model_frame(8'hA5, 1'b1, 1'b0);
        idle_line(2);
        checks++;
        if (observed_vec() !== {1'b1, 5'd1, 8'hA5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_frame: got %h want %h", observed_vec(), {1'b1, 5'd1, 8'hA5, 1'b0, 1'b0});
        end
        do_read();
        checks++;
        if (observed_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL single_read: got %h want %h", observed_vec(), expect_vec());
        end
    endtask

    task automatic test_false_start();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle_line(40);
        checks++;
        if (observed_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL false_start: got %h want %h", observed_vec(), expect_vec());
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        idle_line(6);
        checks++;
        if (observed_vec() !== expect_vec() || ferrout !== 1'b1 || countout !== 5'd0) begin
            errors++;
            $display("FAIL framing_error: got %h want %h", observed_vec(), expect_vec());
        end
        send_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h11, 1'b1, 1'b0);
        idle_line(2);
        checks++;
        if (observed_vec() !== expect_vec() || dataout !== 8'h11) begin
            errors++;
            $display("FAIL frame_after_ferr: got %h want %h", observed_vec(), expect_vec());
        end
        pulse_clr();
        checks++;
        if (ferrout !== 1'b0 || observed_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL ferr_clear: got %h want %h", observed_vec(), expect_vec());
        end
        do_read();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            model_frame(8'(i), 1'b1, 1'b0);
        end
        idle_line(2);
        checks++;
        if (observed_vec() !== expect_vec() || countout !== 5'd16 || ovrout !== 1'b1) begin
            errors++;
            $display("FAIL overrun: got %h want %h", observed_vec(), expect_vec());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dataout !== 8'(i) || dataout !== q[0]) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, dataout, 8'(i));
            end
            do_read();
        end
        checks++;
        if (observed_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL drained: got %h want %h", observed_vec(), expect_vec());
        end
        pulse_clr();
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0);
            model_frame(b, 1'b1, 1'b0);
        end
        send_frame(8'hC3, 1'b1, 1'b1);
        model_frame(8'hC3, 1'b1, 1'b1);
        idle_line(2);
        checks++;
        if (observed_vec() !== expect_vec() || countout !== 5'd16 || ovrout !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: got %h want %h", observed_vec(), expect_vec());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dataout !== q[0]) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %h want %h", i, dataout, q[0]);
            end
            if (i == 15 && dataout !== 8'hC3) begin
                errors++;
                $display("FAIL last_entry: got %h want %h", dataout, 8'hC3);
            end
            do_read();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] frame;
        send_frame(8'h77, 1'b1, 1'b0);
        model_frame(8'h77, 1'b1, 1'b0);
        frame = {1'b1, 8'hF0, 1'b0};
        for (int i = 0; i < 5 * CPB + CPB / 2; i++) begin
            rxd = frame[i / CPB];
            @(negedge clk);
        end
        reset_n = 1'b0;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        @(negedge clk);
        checks++;
        if (observed_vec() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_frame: got %h want %h", observed_vec(), 16'h0000);
        end
        rxd = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        idle_line(CPB * 6);
        checks++;
        if (observed_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL after_reset_idle: got %h want %h", observed_vec(), expect_vec());
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b0);
        idle_line(2);
        checks++;
        if (observed_vec() !== expect_vec() || dataout !== 8'h5A) begin
            errors++;
            $display("FAIL frame_after_reset: got %h want %h", observed_vec(), expect_vec());
        end
        do_read();
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         ok;
        int         nreads;
        for (int it = 0; it < 24; it++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok, 1'b0);
            model_frame(b, ok, 1'b0);
            idle_line(3);
            checks++;
            if (observed_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL random_frame[%0d]: got %h want %h", it, observed_vec(), expect_vec());
            end
            nreads = $urandom_range(0, 3);
            for (int r = 0; r < nreads; r++) begin
                do_read();
                checks++;
                if (observed_vec() !== expect_vec()) begin
                    errors++;
                    $display("FAIL random_read[%0d]: got %h want %h", it, observed_vec(), expect_vec());
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                pulse_clr();
                checks++;
                if (observed_vec() !== expect_vec()) begin
                    errors++;
                    $display("FAIL random_clr[%0d]: got %h want %h", it, observed_vec(), expect_vec());
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_false_start();
        test_framing();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
